// File: rtl/uart_tx_frame.sv
// uart_tx_frame
// Asynchronous serial transmitter. A word offered on the valid/ready
// handshake is sent as one frame on TxOUT:
//   start bit (low), DATA_BITS data bits LSB first, optional parity bit,
//   STOP_BITS stop bits (high).
// Every bit lasts BIT_PERIOD = CLOCK_FREQUENCY / BAUD_RATE clock cycles,
// timed by an internal down-counter, so no external baud tick is needed.
//
// Ports:
//   clockIN   - system clock, everything runs on its rising edge
//   nResetIN  - asynchronous active-low reset, abandons any frame in flight
//   DataIN    - word to send, captured only on the accept edge
//   ValidIN   - DataIN holds a word to send
//   ReadyOUT  - transmitter is idle and will take a word on the next edge
//   TxOUT     - serial line, idles high
//   DoneOUT   - single-cycle pulse on the edge a frame finishes
module uart_tx_frame #(
    parameter int CLOCK_FREQUENCY = 48_000_000,
    parameter int BAUD_RATE       = 9600,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1
) (
    input  logic                 clockIN,
    input  logic                 nResetIN,
    input  logic [DATA_BITS-1:0] DataIN,
    input  logic                 ValidIN,
    output logic                 ReadyOUT,
    output logic                 TxOUT,
    output logic                 DoneOUT
);

    localparam int BIT_PERIOD  = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int COUNT_WIDTH = (BIT_PERIOD < 2) ? 1 : $clog2(BIT_PERIOD);
    localparam int INDEX_WIDTH = $clog2(DATA_BITS);

    localparam logic [COUNT_WIDTH-1:0] COUNT_RELOAD = COUNT_WIDTH'(BIT_PERIOD - 1);
    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX   = INDEX_WIDTH'(DATA_BITS - 1);

    // Reject parameter sets that cannot produce a legal frame.
    if (BIT_PERIOD < 2) begin : gBitPeriodCheck
        $error("uart_tx_frame: CLOCK_FREQUENCY/BAUD_RATE must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : gDataBitsCheck
        $error("uart_tx_frame: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : gParityCheck
        $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : gStopBitsCheck
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY_BIT,
        STOP
    } stateT;

    stateT                  state,      stateNext;
    logic [COUNT_WIDTH-1:0] bitCounter, bitCounterNext;
    logic [INDEX_WIDTH-1:0] bitIndex,   bitIndexNext;
    logic [DATA_BITS-1:0]   shiftReg,   shiftRegNext;
    logic                   parityReg,  parityRegNext;
    logic                   stopIndex,  stopIndexNext;
    logic                   txReg,      txNext;
    logic                   readyReg,   readyNext;
    logic                   doneReg,    doneNext;

    // State register. Every output comes straight from a flop here, so
    // nothing on the input side can reach the outputs combinationally.
    always_ff @(posedge clockIN or negedge nResetIN) begin
        if (!nResetIN) begin
            state      <= IDLE;
            bitCounter <= '0;
            bitIndex   <= '0;
            shiftReg   <= '0;
            parityReg  <= 1'b0;
            stopIndex  <= 1'b0;
            txReg      <= 1'b1;
            readyReg   <= 1'b1;
            doneReg    <= 1'b0;
        end else begin
            state      <= stateNext;
            bitCounter <= bitCounterNext;
            bitIndex   <= bitIndexNext;
            shiftReg   <= shiftRegNext;
            parityReg  <= parityRegNext;
            stopIndex  <= stopIndexNext;
            txReg      <= txNext;
            readyReg   <= readyNext;
            doneReg    <= doneNext;
        end
    end

    // Next-state logic. The line value for the next bit is decided on the
    // same edge the bit counter wraps, so each bit occupies exactly
    // BIT_PERIOD cycles starting from the accept edge. Parity is computed
    // once from the captured word so later DataIN changes cannot affect it.
    always_comb begin
        stateNext      = state;
        bitCounterNext = bitCounter;
        bitIndexNext   = bitIndex;
        shiftRegNext   = shiftReg;
        parityRegNext  = parityReg;
        stopIndexNext  = stopIndex;
        txNext         = txReg;
        readyNext      = readyReg;
        doneNext       = 1'b0;

        if (state == IDLE) begin
            if (ValidIN && readyReg) begin
                shiftRegNext   = DataIN;
                parityRegNext  = (PARITY == 1) ? ~(^DataIN) : (^DataIN);
                txNext         = 1'b0;
                readyNext      = 1'b0;
                bitCounterNext = COUNT_RELOAD;
                stateNext      = START;
            end
        end else if (bitCounter != '0) begin
            bitCounterNext = bitCounter - 1'b1;
        end else begin
            bitCounterNext = COUNT_RELOAD;
            case (state)
                START: begin
                    txNext       = shiftReg[0];
                    shiftRegNext = shiftReg >> 1;
                    bitIndexNext = '0;
                    stateNext    = DATA;
                end
                DATA: begin
                    if (bitIndex == LAST_INDEX) begin
                        if (PARITY != 0) begin
                            txNext    = parityReg;
                            stateNext = PARITY_BIT;
                        end else begin
                            txNext        = 1'b1;
                            stopIndexNext = 1'b0;
                            stateNext     = STOP;
                        end
                    end else begin
                        txNext       = shiftReg[0];
                        shiftRegNext = shiftReg >> 1;
                        bitIndexNext = bitIndex + 1'b1;
                    end
                end
                PARITY_BIT: begin
                    txNext        = 1'b1;
                    stopIndexNext = 1'b0;
                    stateNext     = STOP;
                end
                STOP: begin
                    if (STOP_BITS == 2 && !stopIndex) begin
                        stopIndexNext = 1'b1;
                    end else begin
                        txNext    = 1'b1;
                        readyNext = 1'b1;
                        doneNext  = 1'b1;
                        stateNext = IDLE;
                    end
                end
                default: begin
                    stateNext = IDLE;
                    txNext    = 1'b1;
                    readyNext = 1'b1;
                end
            endcase
        end
    end

    assign TxOUT    = txReg;
    assign ReadyOUT = readyReg;
    assign DoneOUT  = doneReg;

endmodule
